lcd_pattern_gen: RTL
====================

// Module: lcd_pattern_gen
// PURPOSE
//   Test-pattern source directly upstream of the RGB LCD timing driver.
//   - Consumes the driver's pixel_xpos/pixel_ypos/h_disp/v_disp.
//   - Returns registered 24-bit pixel_data with 1-cycle latency, which matches the driver's
//     1-cycle lead of xpos ahead of lcd_de.
//   - Cycles 5 patterns, switching only at frame boundaries (key press or auto timer).
// PARAMETERS
//   AUTO_FRAMES  60  frames per pattern in auto mode (>=1)
//   CHECK_SHIFT  5   checker cell = 2**CHECK_SHIFT pixels square
// PORTS
//   lcd_pclk    in   1   pixel clock, all logic on rising edge
//   rst         in   1   synchronous, active-high reset
//   pixel_xpos  in   11  from driver: 0..h_disp-1 during data request, else 0
//   pixel_ypos  in   11  from driver: 1..v_disp in active lines, 0 in vertical blanking
//   h_disp      in   11  active width (0 when panel ID unknown)
//   v_disp      in   11  active height
//   key_next    in   1   one-cycle pulse, debounced: request next pattern
//   auto_en     in   1   1 = advance every AUTO_FRAMES frames
//   pixel_data  out  24  {R,G,B}, registered
//   pattern_id  out  3   current pattern 0..4
//   frame_start out  1   one-cycle pulse at start of each active frame
// BEHAVIOUR
//   Reset values:
//   - pixel_data=0, pattern_id=0, frame_start=0.
//   - Frame counter=0, pending flag=0, ypos_d=0, bar width W=0.
//   Frame detect:
//   - ypos_d <= pixel_ypos every cycle.
//   - frame_start <= (ypos_d==0 && pixel_ypos!=0), so it is high for 1 cycle.
//   Bar width:
//   - W = (h_disp*205)>>10, 21-bit product, truncated to 11 bits.
//   - Latched only when frame_start is high, so it is stable for the whole frame.
//   - Examples: 480->96, 800->160, 1024->205, 1280->256.
//   Pattern state machine, pattern_id 0..4 wraps to 0 after 4:
//   - 0 COLORBAR: compare xpos against W, 2W, 3W, 4W.
//     - x<W white FFFFFF; <2W black 000000; <3W red FF0000; <4W green 00FF00; else blue 0000FF.
//     - W=0 gives an all-blue screen.
//   - 1 GRAY: {g,g,g} with g=xpos[7:0], a ramp that wraps every 256 px.
//   - 2 CHECKER: white if xpos[CHECK_SHIFT]^ypos[CHECK_SHIFT], else black.
//   - 3 BORDER: white if x==0 | x==h_disp-1 | y==1 | y==v_disp, else black.
//   - 4 RAMP_RGB: {xpos[7:0], ypos[7:0], xpos[7:0]^ypos[7:0]}.
//   pixel_data:
//   - pixel_data <= f(pattern_id, pixel_xpos, pixel_ypos) every cycle, no enable.
//   - The driver masks it with lcd_de.
//   Advance rules, evaluated only in the cycle frame_start is high:
//   - key_next at any cycle sets pending=1.
//   - On frame_start:
//     - fcnt <= fcnt+1.
//     - adv = pending | (auto_en & fcnt==AUTO_FRAMES-1).
//     - If adv: pattern_id <= pattern_id+1 (mod 5), pending <= 0, fcnt <= 0.
//   - Simultaneous key and auto expiry advance exactly once.
//   - key_next in the same cycle as frame_start counts for the NEXT frame.
//   - Multiple key pulses within one frame collapse to one advance.
//   - auto_en=0 holds fcnt at 0.
//   - Clearing auto_en mid-count resets fcnt on the next frame_start.
//   - pattern_id never changes mid-frame, so a frame is never torn.
//   Reset mid-frame:
//   - All state returns to reset values on the next edge.
//   - The first frame_start requires ypos to be seen as 0 first.
//   Widths: fcnt is $clog2(AUTO_FRAMES)+1 bits; all compares are unsigned 11-bit.
// TESTING
//   - Reset held 3 cycles, ypos=5 -> pixel_data=0, pattern_id=0, no frame_start.
//   - h_disp=480, pattern 0, x=95/96/191/383/384/479 -> FFFFFF/000000/000000/00FF00/0000FF/0000FF one cycle later.
//   - key_next at ypos=100 -> pattern_id stays 0 until the ypos 0->1 edge, then 1; two pulses in one frame -> 1 only.
//   - AUTO_FRAMES=2, auto_en=1 -> pattern_id 0,0,1,1,2... across frames; after 4 wraps to 0.
//   - key_next plus auto expiry on same frame -> +1 only, fcnt cleared; h_disp=0 in pattern 0 -> all 0000FF.
//   - Pattern 3, 480x272 -> white at (0,y), (479,y), (x,1), (x,272); black at (1,2); rst mid-line -> pixel_data 0 next cycle.

Source files
------------

// File: rtl/lcd_pattern_gen.sv
// Test-pattern source for the RGB LCD timing driver. It produces registered 24-bit pixels
// with one cycle of latency and changes pattern only at frame boundaries.
module lcd_pattern_gen #(
  parameter int AUTO_FRAMES = 60,
  parameter int CHECK_SHIFT = 5
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  input  logic        key_next,
  input  logic        auto_en,
  output logic [23:0] pixel_data,
  output logic [2:0]  pattern_id,
  output logic        frame_start
);

  localparam int FW = $clog2(AUTO_FRAMES) + 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(AUTO_FRAMES - 1);

  localparam logic [2:0] PAT_COLORBAR = 3'd0;
  localparam logic [2:0] PAT_GRAY     = 3'd1;
  localparam logic [2:0] PAT_CHECKER  = 3'd2;
  localparam logic [2:0] PAT_BORDER   = 3'd3;
  localparam logic [2:0] PAT_RAMP_RGB = 3'd4;

  logic [10:0]   ypos_d_r;
  logic          seen_zero_r;
  logic [10:0]   bar_w_r;
  logic [FW-1:0] fcnt_r;
  logic          pending_r;
  logic          adv_s;
  logic [2:0]    pat_next_s;
  logic          border_s;
  logic [23:0]   pix_s;

  function automatic logic [23:0] colorbar(input logic [10:0] x, input logic [10:0] w);
    logic [10:0] w2;
    logic [10:0] w3;
    logic [10:0] w4;
    w2 = {w[9:0], 1'b0};
    w3 = w2 + w;
    w4 = {w[8:0], 2'b00};
    if (x < w)       colorbar = 24'hFFFFFF;
    else if (x < w2) colorbar = 24'h000000;
    else if (x < w3) colorbar = 24'hFF0000;
    else if (x < w4) colorbar = 24'h00FF00;
    else             colorbar = 24'h0000FF;
  endfunction

  always_comb begin
    adv_s = pending_r | (auto_en & (fcnt_r == FCNT_LAST));
    if (pattern_id >= PAT_RAMP_RGB) begin
      pat_next_s = PAT_COLORBAR;
    end else begin
      pat_next_s = pattern_id + 3'd1;
    end
  end

  always_comb begin
    border_s = (pixel_xpos == 11'd0) | (pixel_xpos == (h_disp - 11'd1)) |
               (pixel_ypos == 11'd1) | (pixel_ypos == v_disp);
    pix_s = 24'h000000;
    case (pattern_id)
      PAT_COLORBAR: pix_s = colorbar(pixel_xpos, bar_w_r);
      PAT_GRAY:     pix_s = {pixel_xpos[7:0], pixel_xpos[7:0], pixel_xpos[7:0]};
      PAT_CHECKER:  pix_s = (pixel_xpos[CHECK_SHIFT] ^ pixel_ypos[CHECK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
      PAT_BORDER:   pix_s = border_s ? 24'hFFFFFF : 24'h000000;
      PAT_RAMP_RGB: pix_s = {pixel_xpos[7:0], pixel_ypos[7:0], pixel_xpos[7:0] ^ pixel_ypos[7:0]};
      default:      pix_s = 24'h000000;
    endcase
  end

  // Frame edge detect; a blanking line must be seen after reset before the first pulse.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      ypos_d_r    <= 11'd0;
      seen_zero_r <= 1'b0;
      frame_start <= 1'b0;
      bar_w_r     <= 11'd0;
    end else begin
      ypos_d_r    <= pixel_ypos;
      seen_zero_r <= seen_zero_r | (pixel_ypos == 11'd0);
      frame_start <= seen_zero_r & (ypos_d_r == 11'd0) & (pixel_ypos != 11'd0);
      if (frame_start) begin
        bar_w_r <= 11'(({10'd0, h_disp} * 21'd205) >> 10);
      end
    end
  end

  // Pattern sequencing; a key arriving in the frame_start cycle is kept for the next frame.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      pattern_id <= PAT_COLORBAR;
      fcnt_r     <= '0;
      pending_r  <= 1'b0;
    end else if (frame_start) begin
      pending_r <= key_next;
      if (adv_s) begin
        pattern_id <= pat_next_s;
        fcnt_r     <= '0;
      end else if (auto_en) begin
        fcnt_r <= fcnt_r + FW'(1);
      end else begin
        fcnt_r <= '0;
      end
    end else begin
      pending_r <= pending_r | key_next;
    end
  end

  // Registered pixel output, consumed one cycle later under lcd_de.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      pixel_data <= 24'h000000;
    end else begin
      pixel_data <= pix_s;
    end
  end

endmodule
